// File: rtl/instr_loader.sv
// instr_loader: boot-time program loader in front of the instruction ROM.
// Takes a little-endian byte stream (count lo, count hi, then N two-byte
// words), writes 9-bit words to instruction memory from address 0, holds
// the core in reset while loading, then releases it and waits for done.
//
// Optional feature: define INSTR_LOADER_CHECKSUM_EN to require a trailing
// XOR checksum byte (state CHK) before the core is released.
//
// Ports:
//   clk, reset       clock, async active-low reset
//   in_data/valid/ready  byte stream handshake
//   wr_en/addr/data  registered instruction memory write port
//   core_rst_n       active-low core reset, high only in RUN/HALT
//   core_done        core done flag, sampled in RUN
//   restart          pulse, starts a new load from HALT or ERR
//   busy/halted/error  status
module instr_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [8:0]        wr_data,
  output logic              core_rst_n,
  input  logic              core_done,
  input  logic              restart,
  output logic              busy,
  output logic              halted,
  output logic              error
);

  typedef enum logic [2:0] {
    S_CNT_LO, S_CNT_HI, S_W_LO, S_W_HI, S_RUN, S_HALT, S_ERR, S_CHK
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_t              state_q, state_d;
  logic [7:0]          lo_q;      // count low byte, then word low byte
  logic [ADDR_W:0]     rem_q;     // words still to be written
  logic [ADDR_W-1:0]   addr_q;    // next write address
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [8:0]          wr_data_q;
  logic                core_rst_n_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q;
`endif

  logic            acc;
  logic            restart_go;
  logic [ADDR_W:0] cnt_w;
  logic            hi_bad;

  assign acc        = in_valid && in_ready;
  assign restart_go = restart && (state_q == S_HALT || state_q == S_ERR);
  // The high byte contributes enough bits to form an ADDR_W+1 bit count,
  // so a full-depth image is representable and oversize counts are caught.
  assign cnt_w      = {in_data[ADDR_W-8:0], lo_q};
  assign hi_bad     = |in_data[7:1];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_CNT_LO;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CNT_LO: if (acc) state_d = S_CNT_HI;
      S_CNT_HI: if (acc) state_d = (cnt_w == '0 || cnt_w > DEPTH_C) ? S_ERR : S_W_LO;
      S_W_LO:   if (acc) state_d = S_W_HI;
      S_W_HI: if (acc) begin
        if (hi_bad)              state_d = S_ERR;
        else if (rem_q == ONE_C)
`ifdef INSTR_LOADER_CHECKSUM_EN
                                 state_d = S_CHK;
`else
                                 state_d = S_RUN;
`endif
        else                     state_d = S_W_LO;
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHK:    if (acc) state_d = (in_data == csum_q) ? S_RUN : S_ERR;
`endif
      S_RUN:    if (core_done) state_d = S_HALT;
      S_HALT,
      S_ERR:    if (restart) state_d = S_CNT_LO;
      default:  state_d = S_CNT_LO;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    halted   = 1'b0;
    error    = 1'b0;
    case (state_q)
      S_CNT_LO, S_CNT_HI, S_W_LO, S_W_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      S_HALT:  halted = 1'b1;
      S_ERR:   error  = 1'b1;
      default: ;
    endcase
  end

  // Datapath: word assembly, write port, counters, core reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_q         <= '0;
      rem_q        <= '0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      core_rst_n_q <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      // Released only once RUN has been held for a cycle, so the final
      // write strobe is always retired before the core comes out of reset;
      // leaving RUN/HALT (restart) drops it on the same edge.
      core_rst_n_q <= (state_q == S_RUN || state_q == S_HALT) &&
                      (state_d == S_RUN || state_d == S_HALT);
      if (acc) begin
        case (state_q)
          S_CNT_LO, S_W_LO: lo_q <= in_data;
          S_CNT_HI:         rem_q <= cnt_w;
          S_W_HI: if (!hi_bad) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= {in_data[0], lo_q};
            addr_q    <= addr_q + ADDR_W'(1);
            rem_q     <= rem_q - ONE_C;
          end
          default: ;
        endcase
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (state_q != S_CHK) csum_q <= csum_q ^ in_data;
`endif
      end
      if (restart_go) begin
        lo_q      <= '0;
        rem_q     <= '0;
        addr_q    <= '0;
        wr_addr_q <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum_q    <= '0;
`endif
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign core_rst_n = core_rst_n_q;

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [8:0]        wr_data;
  logic              core_rst_n;
  logic              core_done = 1'b0;
  logic              restart = 1'b0;
  logic              busy, halted, error;

  instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_rst_n(core_rst_n), .core_done(core_done), .restart(restart),
    .busy(busy), .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  logic [ADDR_W+8:0] exp_q[$];   // model: expected {addr,data} writes
  logic [ADDR_W+8:0] log_q[$];   // writes observed from the DUT
  logic [ADDR_W+8:0] t1_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: parse a byte image into the write list and verdict.
  task automatic model(input logic [7:0] s[$], output bit err);
    int cnt;
    logic [7:0] x;
    err = 1'b0;
    cnt = int'({s[1][2:0], s[0]});
    x = s[0] ^ s[1];
    if (cnt == 0 || cnt > DEPTH) begin err = 1'b1; return; end
    for (int i = 0; i < cnt; i++) begin
      if (3 + 2*i >= s.size()) return;
      if (s[3+2*i][7:1] != 0) begin err = 1'b1; return; end
      exp_q.push_back({ADDR_W'(i), s[3+2*i][0], s[2+2*i]});
      x = x ^ s[2+2*i] ^ s[3+2*i];
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    if (s.size() > 2 + 2*cnt) err = (s[2+2*cnt] != x);
`endif
  endtask

  // Append the trailing checksum when the build expects one.
  task automatic seal(inout logic [7:0] s[$]);
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] x = '0;
    foreach (s[i]) x ^= s[i];
    s.push_back(x);
`endif
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) begin
      ntests++; nfail++;
      $display("FAIL accept_timeout: byte %0h not accepted", b);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] s[$], input bit gap);
    foreach (s[i]) begin
      send_byte(s[i]);
      if (gap) @(negedge clk);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},   in_ready,   1);
    chk({tag, "_wr_en"},      wr_en,      0);
    chk({tag, "_wr_addr"},    wr_addr,    0);
    chk({tag, "_wr_data"},    wr_data,    0);
    chk({tag, "_core_rst_n"}, core_rst_n, 0);
    chk({tag, "_busy"},       busy,       1);
    chk({tag, "_halted"},     halted,     0);
    chk({tag, "_error"},      error,      0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    chk("exp_writes_drained", exp_q.size(), 0);
    exp_q.delete();
    log_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  // Compare process: every write against the model, plus invariants.
  always @(negedge clk) begin
    if (reset) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          ntests++; nfail++;
          $display("FAIL unexpected_write: addr %0h data %0h, expected none", wr_addr, wr_data);
        end else begin
          chk("write", {wr_addr, wr_data}, exp_q.pop_front());
        end
        log_q.push_back({wr_addr, wr_data});
      end
      chk("ready_while_core_live", in_ready & core_rst_n, 0);
      chk("write_while_core_live", wr_en & core_rst_n, 0);
    end
  end

  initial begin
    logic [7:0] s[$];
    bit err;

    @(negedge clk);
    chk_reset_vals("rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // T1: three words, continuous valid
    s = '{8'h03, 8'h00, 8'hA5, 8'h01, 8'h03, 8'h00, 8'hFF, 8'h00};
    seal(s);
    model(s, err);
    chk("t1_model_err", err, 0);
    send(s, 1'b0);
`ifdef INSTR_LOADER_CHECKSUM_EN
    chk("t1_wait_rst", core_rst_n, 0);
`else
    chk("t1_last_wr", wr_en, 1);
    chk("t1_rst_with_wr", core_rst_n, 0);
`endif
    @(negedge clk);
    chk("t1_rst_rise", core_rst_n, 1);
    chk("t1_busy", busy, 0);
    @(negedge clk);
    chk("t1_nwrites", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("t1_w0", log_q[0], {10'd0, 9'h1A5});
      chk("t1_w1", log_q[1], {10'd1, 9'h003});
      chk("t1_w2", log_q[2], {10'd2, 9'h0FF});
    end
    t1_log = log_q;
    do_reset();

    // T2: two words, valid toggled every other cycle
    s = '{8'h02, 8'h00, 8'hA5, 8'h01, 8'h03, 8'h00};
    seal(s);
    model(s, err);
    send(s, 1'b1);
    repeat (2) @(negedge clk);
    chk("t2_core_rst", core_rst_n, 1);
    chk("t2_nwrites", log_q.size(), 2);
    if (log_q.size() == 2 && t1_log.size() == 3) begin
      chk("t2_same_w0", log_q[0], t1_log[0]);
      chk("t2_same_w1", log_q[1], t1_log[1]);
    end
    in_data = 8'hAA; in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t2_ready_in_run", in_ready, 0);
    end
    in_valid = 1'b0;
    do_reset();

    // T3: count 0, then (after restart) count 0x0401 -> ERR, no writes
    s = '{8'h00, 8'h00};
    model(s, err);
    chk("t3_model_err0", err, 1);
    send(s, 1'b0);
    repeat (2) @(negedge clk);
    chk("t3_err0", error, 1);
    chk("t3_rst0", core_rst_n, 0);
    chk("t3_ready0", in_ready, 0);
    pulse_restart();
    chk("t3_restart_ready", in_ready, 1);
    s = '{8'h01, 8'h04};
    model(s, err);
    chk("t3_model_err401", err, 1);
    send(s, 1'b0);
    repeat (2) @(negedge clk);
    chk("t3_err401", error, 1);
    chk("t3_rst401", core_rst_n, 0);
    chk("t3_nwrites", log_q.size(), 0);
    do_reset();

    // T4: third word high byte 0x03 -> ERR with no write for it
    s = '{8'h03, 8'h00, 8'h11, 8'h00, 8'h22, 8'h01, 8'h33, 8'h03};
    model(s, err);
    send(s, 1'b0);
    repeat (2) @(negedge clk);
    chk("t4_err", error, 1);
    chk("t4_nwrites", log_q.size(), 2);
    chk("t4_addr_before", wr_addr, 1);
    pulse_restart();
    chk("t4_addr_after", wr_addr, 0);
    chk("t4_ready", in_ready, 1);
    chk("t4_busy", busy, 1);
    chk("t4_err_clr", error, 0);
    do_reset();

    // T5: one word, core_done -> HALT; then reset mid-load
    s = '{8'h01, 8'h00, 8'h55, 8'h00};
    seal(s);
    model(s, err);
    send(s, 1'b0);
    repeat (2) @(negedge clk);
    chk("t5_core_rst", core_rst_n, 1);
    core_done = 1'b1;
    chk("t5_not_yet_halt", halted, 0);
    @(negedge clk);
    core_done = 1'b0;
    chk("t5_halted", halted, 1);
    chk("t5_core_rst_halt", core_rst_n, 1);
    pulse_restart();
    chk("t5_restart_rst", core_rst_n, 0);
    chk("t5_restart_halt", halted, 0);
    s = '{8'h03, 8'h00, 8'h10, 8'h00, 8'h20, 8'h01, 8'h30, 8'h00};
    model(s, err);
    s = '{8'h03, 8'h00, 8'h10, 8'h00, 8'h20, 8'h01};
    send(s, 1'b0);
    chk("t5_mid_wr", wr_en, 1);
    #2 reset = 1'b0;
    #1 chk_reset_vals("async_rst");
    exp_q.delete();
    log_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Checksum: good byte -> RUN, bad byte -> ERR
    s = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h01};
    model(s, err);
    chk("ck_model_ok", err, 0);
    send(s, 1'b0);
    chk("ck_rst_low", core_rst_n, 0);
    @(negedge clk);
    chk("ck_rst_rise", core_rst_n, 1);
    chk("ck_err_ok", error, 0);
    do_reset();
    s = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h00};
    model(s, err);
    chk("ck_model_bad", err, 1);
    send(s, 1'b0);
    repeat (2) @(negedge clk);
    chk("ck_err_bad", error, 1);
    chk("ck_rst_bad", core_rst_n, 0);
    do_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
